// File: rtl/arith_pkg.sv
// Shared encodings for the sequential N-bit arithmetic unit.
//   op_e    : operation select carried on op_in
//   state_e : control FSM states of arith_seq_nbit
package arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_ACC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/arith_seq_mul_core.sv
// N-step shift-add unsigned multiplier datapath.
//   clk_in, rst_in : clock, synchronous active-high reset
//   start          : load operands a/b and clear the partial product
//   a, b           : unsigned N-bit operands (sampled on start)
//   product        : partial product including the step in progress (2N bits);
//                    equals a*b in the cycle where last_step is high
//   last_step      : the step taken at the next edge is the N-th
module arith_seq_mul_core #(
  parameter int N = 4
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           last_step
);
  localparam int CW = $clog2(N) + 1;

  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;

  // Product is exposed one step ahead so the top can register the final
  // value on the same edge that performs the last step.
  assign product   = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign last_step = busy_q && (cnt_q == CW'(N - 1));

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = {{N{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      prod_d   = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last_step) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/arith_seq_nbit.sv
// Sequential N-bit arithmetic unit: ADD, SUB, shift-add MUL, ACC.
//   clk_in, rst_in      : clock, synchronous active-high reset
//   valid_in/ready_out  : operand handshake; accept when both high
//   op_in, a_in, b_in   : operation and unsigned operands
//   result_out          : registered 2N-bit result, held until next result
//   carry_out           : carry / borrow / 0 / accumulator wrap
//   valid_out           : one-cycle pulse while in DONE
module arith_seq_nbit
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           valid_in,
  output logic           ready_out,
  input  logic [1:0]     op_in,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic [2*N-1:0] result_out,
  output logic           carry_out,
  output logic           valid_out
);
  state_e         state_q, state_d;
  logic [2*N-1:0] result_q, result_d;
  logic           carry_q, carry_d;
  logic [2*N-1:0] acc_q, acc_d;

  logic           accept;
  logic           mul_start;
  logic [2*N-1:0] mul_product;
  logic           mul_last;
  logic [N:0]     add_sum;
  logic [2*N:0]   acc_sum;

  assign ready_out  = (state_q == ST_IDLE);
  assign valid_out  = (state_q == ST_DONE);
  assign result_out = result_q;
  assign carry_out  = carry_q;
  assign accept     = valid_in && ready_out;

  assign add_sum = {1'b0, a_in} + {1'b0, b_in};
  assign acc_sum = {1'b0, acc_q} + {{(N+1){1'b0}}, a_in};

  arith_seq_mul_core #(.N(N)) u_mul (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start     (mul_start),
    .a         (a_in),
    .b         (b_in),
    .product   (mul_product),
    .last_step (mul_last)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    carry_d   = carry_q;
    acc_d     = acc_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DONE;
          case (op_e'(op_in))
            OP_ADD: begin
              result_d = {{N{1'b0}}, add_sum[N-1:0]};
              carry_d  = add_sum[N];
            end
            OP_SUB: begin
              result_d = {{N{1'b0}}, a_in - b_in};
              carry_d  = (a_in < b_in);
            end
            OP_MUL: begin
              state_d   = ST_MUL;
              mul_start = 1'b1;
            end
            default: begin // OP_ACC
              acc_d    = acc_sum[2*N-1:0];
              result_d = acc_sum[2*N-1:0];
              carry_d  = acc_sum[2*N];
            end
          endcase
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          result_d = mul_product;
          carry_d  = 1'b0;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_arith_seq_nbit.sv
// Directed bench for arith_seq_nbit at N=4 with hand-computed expectations.
module tb_arith_seq_nbit;
  localparam int N = 4;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         valid_in;
  logic         ready_out;
  logic [1:0]   op_in;
  logic [N-1:0] a_in, b_in;
  logic [2*N-1:0] result_out;
  logic         carry_out;
  logic         valid_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_in = ~clk_in;

  arith_seq_nbit #(.N(N)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .op_in      (op_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .result_out (result_out),
    .carry_out  (carry_out),
    .valid_out  (valid_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs and checks both happen 1 time unit after the edge
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // present one op while ready, let it be accepted; returns in the cycle after accept
  task automatic do_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    op_in = op; a_in = a; b_in = b; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic chk_done(input string tag, input logic [7:0] res, input logic cy);
    chk({tag, ".vld"}, 32'(valid_out), 32'd1);
    chk({tag, ".res"}, 32'(result_out), 32'(res));
    chk({tag, ".cy"},  32'(carry_out), 32'(cy));
  endtask

  // MUL: accept, then 3 more MUL cycles, then DONE
  task automatic run_mul(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [7:0] res);
    do_op(2'b10, a, b);
    for (int i = 0; i < 4; i++) begin
      chk({tag, ".busy_vld"}, 32'(valid_out), 32'd0);
      tick();
    end
    chk_done(tag, res, 1'b0);
    tick();
  endtask

  initial begin
    rst_in = 1'b1; valid_in = 1'b0; op_in = 2'b00; a_in = '0; b_in = '0;
    #1;
    tick(); tick();
    rst_in = 1'b0;
    chk("rst.rdy", 32'(ready_out), 32'd1);
    chk("rst.vld", 32'(valid_out), 32'd0);
    chk("rst.res", 32'(result_out), 32'd0);
    chk("rst.cy",  32'(carry_out), 32'd0);

    // ADD overflow
    do_op(2'b00, 4'd9, 4'd8);
    chk("add.rdy_busy", 32'(ready_out), 32'd0);
    chk_done("add9_8", 8'h01, 1'b1);
    tick();
    chk("add.rdy_back", 32'(ready_out), 32'd1);
    chk("add.vld_off",  32'(valid_out), 32'd0);
    chk("add.hold",     32'(result_out), 32'h01);
    do_op(2'b00, 4'd15, 4'd15); chk_done("add15_15", 8'h0E, 1'b1); tick();
    do_op(2'b00, 4'd0, 4'd0);   chk_done("add0_0", 8'h00, 1'b0);   tick();

    // SUB with and without borrow
    do_op(2'b01, 4'd3, 4'd5); chk_done("sub3_5", 8'h0E, 1'b1); tick();
    do_op(2'b01, 4'd5, 4'd3); chk_done("sub5_3", 8'h02, 1'b0); tick();
    do_op(2'b01, 4'd15, 4'd15); chk_done("sub15_15", 8'h00, 1'b0); tick();

    // MUL max with a competing ADD held on the inputs throughout
    op_in = 2'b10; a_in = 4'd15; b_in = 4'd15; valid_in = 1'b1;
    tick();
    op_in = 2'b00; a_in = 4'd1; b_in = 4'd1;
    for (int c = 1; c <= 5; c++) begin
      chk("mul.rdy_low", 32'(ready_out), 32'd0);
      chk("mul.vld", 32'(valid_out), 32'(c == 5));
      if (c < 5) tick();
    end
    chk("mul.res", 32'(result_out), 32'hE1);
    chk("mul.cy",  32'(carry_out), 32'd0);
    tick();
    chk("busy.rdy", 32'(ready_out), 32'd1);
    chk("busy.hold", 32'(result_out), 32'hE1);
    tick();
    valid_in = 1'b0;
    chk_done("busy.add", 8'h02, 1'b0);
    tick();
    chk("busy.once", 32'(valid_out), 32'd0);

    run_mul("mul0_15", 4'd0, 4'd15, 8'h00);
    run_mul("mul13_11", 4'd13, 4'd11, 8'h8F);

    // ACC sequence from a clean accumulator
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      do_op(2'b11, 4'd15, 4'd0);
      if (k <= 3)  chk_done("acc.seq", 8'(15 * k), 1'b0);
      if (k == 17) chk_done("acc17", 8'hFF, 1'b0);
      if (k == 18) chk_done("acc18", 8'h0E, 1'b1);
      tick();
    end
    // accumulator survives a non-ACC op
    do_op(2'b00, 4'd2, 4'd3); chk_done("acc.mid_add", 8'h05, 1'b0); tick();
    do_op(2'b11, 4'd1, 4'd0); chk_done("acc.persist", 8'h0F, 1'b0); tick();

    // Reset two cycles into a MUL
    do_op(2'b10, 4'd15, 4'd15);
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("rmul.vld", 32'(valid_out), 32'd0);
    chk("rmul.res", 32'(result_out), 32'd0);
    chk("rmul.cy",  32'(carry_out), 32'd0);
    chk("rmul.rdy", 32'(ready_out), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rmul.no_pulse", 32'(valid_out), 32'd0);
    end
    do_op(2'b11, 4'd1, 4'd0); chk_done("rmul.acc", 8'h01, 1'b0); tick();

    // reset wins over a simultaneous valid_in
    op_in = 2'b00; a_in = 4'd3; b_in = 4'd3; valid_in = 1'b1; rst_in = 1'b1;
    tick();
    valid_in = 1'b0; rst_in = 1'b0;
    chk("rstv.rdy", 32'(ready_out), 32'd1);
    chk("rstv.vld", 32'(valid_out), 32'd0);
    tick();
    chk("rstv.no_op", 32'(valid_out), 32'd0);
    chk("rstv.res", 32'(result_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
